cpuc_sequencer: RTL and testbench
=================================

Name: cpuc_sequencer

Overview:
- Instruction sequencer for the CPUC connection-matrix datapath.
- Holds the program store of PROGRAM_SIZE configuration words and steps a program counter through it.
- For each step, presents one INST_LENGTH-bit buffer-enable vector to the register/unit crossbar.
- Handles datapath stalls, branch redirects from the comparator/equal units, halt detection, and program loading while stopped.

Parameters:
- PROGRAM_SIZE, 8, number of instruction words in the program store.
- INST_LENGTH, 248, width of one crossbar configuration word: 19 components x 8 regs + 8 regs x 6 units x 2.
- PC_WIDTH, $clog2(PROGRAM_SIZE) = 3, program counter width.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous active-high reset.
- start  in  1  begin execution at pc=0; sampled in IDLE/HALT only.
- stop  in  1  request return to IDLE.
- prog_wr_en  in  1  program store write strobe.
- prog_wr_addr  in  PC_WIDTH  write address.
- prog_wr_data  in  INST_LENGTH  write data.
- dp_stall  in  1  datapath busy; hold the current instruction.
- branch_valid  in  1  redirect request, sampled in EXEC.
- branch_target  in  PC_WIDTH  redirect address.
- inst_config  out  INST_LENGTH  crossbar enables; zero when inst_valid=0.
- inst_valid  out  1  inst_config is live this cycle.
- pc  out  PC_WIDTH  current program counter.
- running  out  1  state is FETCH or EXEC.
- halted  out  1  state is HALT.
- done  out  1  one-cycle pulse on entry to HALT.
- prog_wr_err  out  1  one-cycle pulse, cycle after a rejected write.

Behaviour:
- Reset (synchronous, active-high Rst):
  - state=IDLE, pc=0, instruction register=0.
  - All outputs 0.
  - All program store words cleared to 0.
  - Reset mid-run aborts immediately; no done pulse is generated.
- Program store:
  - Write-only from ports; read internally with a registered read.
  - Writes are accepted only in IDLE or HALT: mem[prog_wr_addr] <= prog_wr_data.
  - A write in FETCH or EXEC is dropped and prog_wr_err=1 on the next cycle.
- Halt marker: an all-zero word.
- States:
  - IDLE: outputs quiet.
    - start -> FETCH, pc<=0.
    - A write and start in the same cycle are both honoured; the following FETCH sees the new data.
  - FETCH (1 cycle): instruction register <= mem[pc].
    - stop -> IDLE.
    - Fetched word all-zero -> HALT; the word is never issued.
    - Otherwise -> EXEC.
  - EXEC: inst_valid=1, inst_config=instruction register.
    - If dp_stall=1: stay in EXEC, outputs held, branch_valid and stop ignored.
    - If dp_stall=0 and stop=1: -> IDLE, pc unchanged. Stop takes priority over branch.
    - Else if branch_valid: pc<=branch_target, -> FETCH.
    - Else if pc==PROGRAM_SIZE-1: -> HALT, no wrap.
    - Else: pc<=pc+1, -> FETCH.
  - HALT: halted=1; done pulses on the entry cycle only.
    - start -> FETCH, pc<=0.
    - stop -> IDLE.
- Timing:
  - Unstalled throughput is 1 instruction per 2 cycles.
  - First inst_valid occurs 2 cycles after the start sample.
- pc arithmetic: unsigned PC_WIDTH bits; branch_target is used verbatim, with no range check when PROGRAM_SIZE is a power of two.
- Output derivation:
  - running = (FETCH | EXEC).
  - halted = HALT.
  - inst_valid is registered or derived from state, and is never high outside EXEC.

Test Plan:
- Reset then start with an empty store -> FETCH reads 0; HALT 2 cycles after start; done=1 for exactly 1 cycle; inst_valid never high.
- Load words 0..3 = 248'h1, 'h2, 'h4, 'h8, word 4 = 0; start -> inst_config shows 1, 2, 4, 8 on every second cycle, pc=0..3; halt with pc=4; done pulse.
- Load all 8 words non-zero; start -> 8 issues, pc reaches 7, HALT without wrap; restart with start -> pc=0 and the same sequence repeats.
- Word 2 executing with branch_valid=1, branch_target=0 -> next issue is word 0; pc goes 2 -> 0; loop continues until branch_valid drops.
- dp_stall high for 3 cycles during word 1, with branch_valid=1 asserted while stalled -> inst_config held 3 extra cycles; branch ignored while stalled; pc advances to 2 only after dp_stall falls.
- prog_wr_en during EXEC -> prog_wr_err=1 the next cycle and the store is unchanged (verified on re-run). stop during EXEC -> IDLE, running=0. Rst asserted mid-run -> IDLE, pc=0, store zeroed.

Source files
------------

// File: rtl/cpuc_sequencer.sv
// Instruction sequencer for the CPUC connection matrix: steps a program counter through a small
// program store and presents one crossbar buffer-enable word per executed step.
module cpuc_sequencer #(
    parameter int PROGRAM_SIZE = 8,
    parameter int INST_LENGTH  = 248,
    parameter int PC_WIDTH     = $clog2(PROGRAM_SIZE)
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   prog_wr_en,
    input  logic [PC_WIDTH-1:0]    prog_wr_addr,
    input  logic [INST_LENGTH-1:0] prog_wr_data,
    input  logic                   dp_stall,
    input  logic                   branch_valid,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [INST_LENGTH-1:0] inst_config,
    output logic                   inst_valid,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   running,
    output logic                   halted,
    output logic                   done,
    output logic                   prog_wr_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [PC_WIDTH-1:0] PC_LAST = PC_WIDTH'(PROGRAM_SIZE - 1);

    logic [1:0]             state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INST_LENGTH-1:0] ir_q, ir_d;
    logic                   done_q, done_d;
    logic                   wr_err_q, wr_err_d;
    logic [INST_LENGTH-1:0] mem_q [PROGRAM_SIZE];

    logic                   stopped;
    logic                   wr_accept;
    logic [INST_LENGTH-1:0] fetch_word;

    // The store may only change while no program is in flight.
    assign stopped    = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign wr_accept  = prog_wr_en && stopped;
    assign fetch_word = mem_q[pc_q];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        wr_err_d = prog_wr_en && !stopped;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                ir_d = fetch_word;
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (fetch_word == '0) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // A stalled datapath freezes the step; stop and branch wait for it to clear.
                if (!dp_stall) begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (branch_valid) begin
                        pc_d    = branch_target;
                        state_d = ST_FETCH;
                    end else if (pc_q == PC_LAST) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = pc_q + PC_WIDTH'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end else if (stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_HALT) && (state_q != ST_HALT);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            for (int i = 0; i < PROGRAM_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
            if (wr_accept) begin
                mem_q[prog_wr_addr] <= prog_wr_data;
            end
        end
    end

    assign inst_valid  = (state_q == ST_EXEC);
    assign inst_config = inst_valid ? ir_q : '0;
    assign pc          = pc_q;
    assign running     = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign halted      = (state_q == ST_HALT);
    assign done        = done_q;
    assign prog_wr_err = wr_err_q;

endmodule

// File: tb/tb_cpuc_sequencer.sv
// Bench for cpuc_sequencer: directed scenarios plus randomized programs checked against a
// per-instruction model of the program walk.
module tb_cpuc_sequencer;

    localparam int PS = 8;
    localparam int IL = 248;
    localparam int PW = 3;

    // Flag vector order: {running, halted, done, inst_valid, prog_wr_err}
    localparam logic [4:0] F_IDLE       = 5'b00000;
    localparam logic [4:0] F_FETCH      = 5'b10000;
    localparam logic [4:0] F_EXEC       = 5'b10010;
    localparam logic [4:0] F_HALT_ENTRY = 5'b01100;
    localparam logic [4:0] F_HALT       = 5'b01000;
    localparam logic [4:0] F_ERR        = 5'b00001;

    logic          Clk, Rst, start, stop, prog_wr_en, dp_stall, branch_valid;
    logic [PW-1:0] prog_wr_addr, branch_target;
    logic [IL-1:0] prog_wr_data;
    logic [IL-1:0] inst_config;
    logic          inst_valid, running, halted, done, prog_wr_err;
    logic [PW-1:0] pc;
    logic [4:0]    flags;

    assign flags = {running, halted, done, inst_valid, prog_wr_err};

    int n_cmp = 0;
    int n_err = 0;

    logic [IL-1:0] mm [PS];
    logic [IL-1:0] exp_q [$];

    cpuc_sequencer #(.PROGRAM_SIZE(PS), .INST_LENGTH(IL), .PC_WIDTH(PW)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .stop(stop),
        .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr), .prog_wr_data(prog_wr_data),
        .dp_stall(dp_stall), .branch_valid(branch_valid), .branch_target(branch_target),
        .inst_config(inst_config), .inst_valid(inst_valid), .pc(pc),
        .running(running), .halted(halted), .done(done), .prog_wr_err(prog_wr_err)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        start = 0; stop = 0; prog_wr_en = 0; prog_wr_addr = '0; prog_wr_data = '0;
        dp_stall = 0; branch_valid = 0; branch_target = '0;
    endtask

    task automatic write_word(input logic [PW-1:0] a, input logic [IL-1:0] d);
        prog_wr_en = 1; prog_wr_addr = a; prog_wr_data = d;
        @(negedge Clk);
        prog_wr_en = 0;
        mm[a] = d;
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge Clk);
        start = 0;
    endtask

    task automatic go_idle();
        stop = 1;
        @(negedge Clk);
        stop = 0;
    endtask

    function automatic logic [IL-1:0] rand_word();
        logic [IL-1:0] w = '0;
        for (int i = 0; i < 8; i++) w = (w << 32) | IL'($urandom);
        if (w == '0) w = IL'(1);
        return w;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Rst = 1;
        repeat (2) @(negedge Clk);
        n_cmp++; if ({flags, pc} !== {F_IDLE, 3'd0}) begin n_err++; $display("FAIL reset_state got=%b/%0d exp=%b/0", flags, pc, F_IDLE); end
        n_cmp++; if (inst_config !== '0) begin n_err++; $display("FAIL reset_config got=%h exp=0", inst_config); end
        Rst = 0;
        for (int a = 0; a < PS; a++) mm[a] = '0;
        @(negedge Clk);
    endtask

    task automatic test_empty_store();
        pulse_start();
        n_cmp++; if ({flags, pc} !== {F_FETCH, 3'd0}) begin n_err++; $display("FAIL empty_fetch got=%b/%0d exp=%b/0", flags, pc, F_FETCH); end
        @(negedge Clk);
        n_cmp++; if ({flags, pc} !== {F_HALT_ENTRY, 3'd0}) begin n_err++; $display("FAIL empty_halt_entry got=%b/%0d exp=%b/0", flags, pc, F_HALT_ENTRY); end
        n_cmp++; if (inst_config !== '0) begin n_err++; $display("FAIL empty_no_issue got=%h exp=0", inst_config); end
        @(negedge Clk);
        n_cmp++; if (flags !== F_HALT) begin n_err++; $display("FAIL empty_done_once got=%b exp=%b", flags, F_HALT); end
        go_idle();
        n_cmp++; if (flags !== F_IDLE) begin n_err++; $display("FAIL empty_stop_idle got=%b exp=%b", flags, F_IDLE); end
    endtask

    task automatic test_directed_program();
        logic [IL-1:0] exp_w;
        write_word(0, IL'(1)); write_word(1, IL'(2)); write_word(2, IL'(4));
        write_word(3, IL'(8)); write_word(4, '0);
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            exp_w = IL'(1) << k;
            n_cmp++; if ({flags, pc} !== {F_FETCH, PW'(k)}) begin n_err++; $display("FAIL dir_fetch k=%0d got=%b/%0d exp=%b/%0d", k, flags, pc, F_FETCH, k); end
            @(negedge Clk);
            n_cmp++; if ({flags, pc} !== {F_EXEC, PW'(k)}) begin n_err++; $display("FAIL dir_exec k=%0d got=%b/%0d exp=%b/%0d", k, flags, pc, F_EXEC, k); end
            n_cmp++; if (inst_config !== exp_w) begin n_err++; $display("FAIL dir_config k=%0d got=%h exp=%h", k, inst_config, exp_w); end
            @(negedge Clk);
        end
        n_cmp++; if ({flags, pc} !== {F_FETCH, 3'd4}) begin n_err++; $display("FAIL dir_fetch_marker got=%b/%0d exp=%b/4", flags, pc, F_FETCH); end
        @(negedge Clk);
        n_cmp++; if ({flags, pc} !== {F_HALT_ENTRY, 3'd4}) begin n_err++; $display("FAIL dir_halt got=%b/%0d exp=%b/4", flags, pc, F_HALT_ENTRY); end
        @(negedge Clk);
        n_cmp++; if (flags !== F_HALT) begin n_err++; $display("FAIL dir_done_pulse got=%b exp=%b", flags, F_HALT); end
        go_idle();
    endtask

    task automatic test_full_restart();
        for (int a = 0; a < PS; a++) write_word(PW'(a), rand_word());
        for (int run = 0; run < 2; run++) begin
            pulse_start();
            for (int k = 0; k < PS; k++) begin
                n_cmp++; if ({flags, pc} !== {F_FETCH, PW'(k)}) begin n_err++; $display("FAIL full_fetch run=%0d k=%0d got=%b/%0d", run, k, flags, pc); end
                @(negedge Clk);
                n_cmp++; if (inst_config !== mm[k] || pc !== PW'(k)) begin n_err++; $display("FAIL full_exec run=%0d k=%0d got=%h/%0d exp=%h/%0d", run, k, inst_config, pc, mm[k], k); end
                @(negedge Clk);
            end
            n_cmp++; if ({flags, pc} !== {F_HALT_ENTRY, 3'd7}) begin n_err++; $display("FAIL full_halt_nowrap run=%0d got=%b/%0d exp=%b/7", run, flags, pc, F_HALT_ENTRY); end
        end
        go_idle();
    endtask

    task automatic test_branch_loop();
        int k;
        for (int a = 0; a < 3; a++) write_word(PW'(a), rand_word());
        write_word(3, '0);
        pulse_start();
        for (int it = 0; it < 9; it++) begin
            k = it % 3;
            n_cmp++; if ({flags, pc} !== {F_FETCH, PW'(k)}) begin n_err++; $display("FAIL br_fetch it=%0d got=%b/%0d exp=%b/%0d", it, flags, pc, F_FETCH, k); end
            @(negedge Clk);
            n_cmp++; if (inst_config !== mm[k] || pc !== PW'(k)) begin n_err++; $display("FAIL br_exec it=%0d got=%h/%0d exp=%h/%0d", it, inst_config, pc, mm[k], k); end
            if (k == 2 && it < 6) begin branch_valid = 1; branch_target = 0; end
            @(negedge Clk);
            branch_valid = 0;
        end
        n_cmp++; if ({flags, pc} !== {F_FETCH, 3'd3}) begin n_err++; $display("FAIL br_exit_fetch got=%b/%0d exp=%b/3", flags, pc, F_FETCH); end
        @(negedge Clk);
        n_cmp++; if ({flags, pc} !== {F_HALT_ENTRY, 3'd3}) begin n_err++; $display("FAIL br_exit_halt got=%b/%0d exp=%b/3", flags, pc, F_HALT_ENTRY); end
        go_idle();
    endtask

    task automatic test_stall_and_stop();
        pulse_start();
        repeat (2) @(negedge Clk);
        @(negedge Clk);
        n_cmp++; if ({flags, pc} !== {F_EXEC, 3'd1}) begin n_err++; $display("FAIL stall_pre got=%b/%0d exp=%b/1", flags, pc, F_EXEC); end
        dp_stall = 1; branch_valid = 1; branch_target = 0; stop = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            n_cmp++; if ({flags, pc} !== {F_EXEC, 3'd1} || inst_config !== mm[1]) begin n_err++; $display("FAIL stall_hold c=%0d got=%b/%0d/%h exp=%b/1/%h", c, flags, pc, inst_config, F_EXEC, mm[1]); end
        end
        dp_stall = 0; branch_valid = 0; stop = 0;
        @(negedge Clk);
        n_cmp++; if ({flags, pc} !== {F_FETCH, 3'd2}) begin n_err++; $display("FAIL stall_release got=%b/%0d exp=%b/2", flags, pc, F_FETCH); end
        @(negedge Clk);
        n_cmp++; if (inst_config !== mm[2]) begin n_err++; $display("FAIL stall_next got=%h exp=%h", inst_config, mm[2]); end
        stop = 1; branch_valid = 1; branch_target = 0;
        @(negedge Clk);
        stop = 0; branch_valid = 0;
        n_cmp++; if ({flags, pc} !== {F_IDLE, 3'd2} || inst_config !== '0) begin n_err++; $display("FAIL stop_over_branch got=%b/%0d exp=%b/2", flags, pc, F_IDLE); end
    endtask

    task automatic test_write_rules();
        logic [IL-1:0] d, x;
        d = rand_word();
        prog_wr_en = 1; prog_wr_addr = 0; prog_wr_data = d; start = 1;
        @(negedge Clk);
        prog_wr_en = 0; start = 0; mm[0] = d;
        n_cmp++; if ({flags, pc} !== {F_FETCH, 3'd0}) begin n_err++; $display("FAIL wr_start_fetch got=%b/%0d exp=%b/0", flags, pc, F_FETCH); end
        @(negedge Clk);
        n_cmp++; if (inst_config !== d) begin n_err++; $display("FAIL wr_start_same_cycle got=%h exp=%h", inst_config, d); end
        x = rand_word();
        prog_wr_en = 1; prog_wr_addr = 1; prog_wr_data = x;
        @(negedge Clk);
        prog_wr_en = 0;
        n_cmp++; if (flags !== (F_FETCH | F_ERR)) begin n_err++; $display("FAIL exec_wr_err got=%b exp=%b", flags, F_FETCH | F_ERR); end
        @(negedge Clk);
        n_cmp++; if (flags !== F_EXEC || inst_config !== mm[1]) begin n_err++; $display("FAIL exec_wr_dropped got=%b/%h exp=%b/%h", flags, inst_config, F_EXEC, mm[1]); end
        go_idle();
        pulse_start();
        repeat (3) @(negedge Clk);
        n_cmp++; if (pc !== 3'd1 || inst_config !== mm[1]) begin n_err++; $display("FAIL rerun_store_kept got=%0d/%h exp=1/%h", pc, inst_config, mm[1]); end
        go_idle();
    endtask

    task automatic test_reset_midrun();
        pulse_start();
        @(negedge Clk);
        Rst = 1;
        @(negedge Clk);
        Rst = 0;
        for (int a = 0; a < PS; a++) mm[a] = '0;
        n_cmp++; if ({flags, pc} !== {F_IDLE, 3'd0} || inst_config !== '0) begin n_err++; $display("FAIL midrun_reset got=%b/%0d exp=%b/0", flags, pc, F_IDLE); end
        pulse_start();
        @(negedge Clk);
        n_cmp++; if ({flags, pc} !== {F_HALT_ENTRY, 3'd0}) begin n_err++; $display("FAIL midrun_store_zeroed got=%b/%0d exp=%b/0", flags, pc, F_HALT_ENTRY); end
        go_idle();
    endtask

    // Random programs: the model walks the program one instruction at a time, recording the
    // expected issue order and the control decision taken after each issue.
    task automatic test_random_runs(input int n_runs);
        int exp_pc_q[$];
        int dec_q[$];
        int cur, nbr, end_kind, end_pc, d, e_pc;
        logic [IL-1:0] e_w, w;
        for (int r = 0; r < n_runs; r++) begin
            for (int a = 0; a < PS; a++) begin
                if ($urandom_range(0, 5) == 0) w = '0; else w = rand_word();
                write_word(PW'(a), w);
            end
            exp_q.delete(); exp_pc_q.delete(); dec_q.delete();
            cur = 0; nbr = 0; end_kind = 0; end_pc = 0;
            forever begin
                if (mm[cur] == '0) begin end_kind = 0; end_pc = cur; break; end
                exp_q.push_back(mm[cur]);
                exp_pc_q.push_back(cur);
                if ($urandom_range(0, 15) == 0) begin
                    dec_q.push_back(-2); end_kind = 2; end_pc = cur; break;
                end
                if (nbr < 6 && $urandom_range(0, 3) == 0) begin
                    d = $urandom_range(0, PS - 1); nbr++; dec_q.push_back(d); cur = d;
                end else begin
                    dec_q.push_back(-1);
                    if (cur == PS - 1) begin end_kind = 1; end_pc = cur; break; end
                    cur++;
                end
            end
            pulse_start();
            while (exp_q.size() > 0) begin
                e_w = exp_q.pop_front(); e_pc = exp_pc_q.pop_front(); d = dec_q.pop_front();
                n_cmp++; if ({flags, pc} !== {F_FETCH, PW'(e_pc)} || inst_config !== '0) begin n_err++; $display("FAIL rnd_fetch run=%0d got=%b/%0d exp=%b/%0d", r, flags, pc, F_FETCH, e_pc); end
                @(negedge Clk);
                n_cmp++; if ({flags, pc} !== {F_EXEC, PW'(e_pc)} || inst_config !== e_w) begin n_err++; $display("FAIL rnd_exec run=%0d got=%b/%0d/%h exp=%b/%0d/%h", r, flags, pc, inst_config, F_EXEC, e_pc, e_w); end
                repeat ($urandom_range(0, 2)) begin
                    dp_stall = 1; stop = 1'($urandom_range(0, 1));
                    branch_valid = 1'($urandom_range(0, 1)); branch_target = PW'($urandom_range(0, PS - 1));
                    @(negedge Clk);
                    n_cmp++; if ({flags, pc} !== {F_EXEC, PW'(e_pc)} || inst_config !== e_w) begin n_err++; $display("FAIL rnd_stall_hold run=%0d got=%b/%0d exp=%b/%0d", r, flags, pc, F_EXEC, e_pc); end
                end
                dp_stall = 0;
                stop = (d == -2);
                branch_valid = (d >= 0) || (d == -2 && $urandom_range(0, 1) == 1);
                branch_target = (d >= 0) ? PW'(d) : PW'($urandom_range(0, PS - 1));
                @(negedge Clk);
                stop = 0; branch_valid = 0;
            end
            if (end_kind == 0) begin
                n_cmp++; if ({flags, pc} !== {F_FETCH, PW'(end_pc)}) begin n_err++; $display("FAIL rnd_marker_fetch run=%0d got=%b/%0d exp=%b/%0d", r, flags, pc, F_FETCH, end_pc); end
                @(negedge Clk);
                n_cmp++; if ({flags, pc} !== {F_HALT_ENTRY, PW'(end_pc)}) begin n_err++; $display("FAIL rnd_marker_halt run=%0d got=%b/%0d exp=%b/%0d", r, flags, pc, F_HALT_ENTRY, end_pc); end
            end else if (end_kind == 1) begin
                n_cmp++; if ({flags, pc} !== {F_HALT_ENTRY, PW'(end_pc)}) begin n_err++; $display("FAIL rnd_end_halt run=%0d got=%b/%0d exp=%b/%0d", r, flags, pc, F_HALT_ENTRY, end_pc); end
            end else begin
                n_cmp++; if ({flags, pc} !== {F_IDLE, PW'(end_pc)}) begin n_err++; $display("FAIL rnd_stop run=%0d got=%b/%0d exp=%b/%0d", r, flags, pc, F_IDLE, end_pc); end
            end
            go_idle();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        Rst = 0;
        clear_inputs();
        test_reset();
        test_empty_store();
        test_directed_program();
        test_full_restart();
        test_branch_loop();
        test_stall_and_stop();
        test_write_rules();
        test_reset_midrun();
        test_random_runs(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
